// File: rtl/proc_pkg.sv
// Shared definitions for the processor and its program sequencer:
// sequencer state encodings, default sizes and processor opcodes.
package proc_pkg;

  localparam int PROG_DEPTH_DEF = 256;
  localparam int WORD_W_DEF     = 10;
  localparam int PM_ADDR_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FILL = 3'd2,
    ST_RUN  = 3'd3,
    ST_STEP = 3'd4
  } seq_state_t;

  // Processor opcodes (upper four bits of a program word).
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/prog_addr_ctr.sv
// Program-memory address / fill counter with clear, increment and
// terminal-count flag (count == DEPTH-1).
module prog_addr_ctr #(
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [7:0] o_count,
  output logic       o_tc
);

  localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

  logic [7:0] r_count;

  // Clear has priority over increment; reset clears everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == LAST_ADDR);

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: downloads a program into program memory (zero-filling
// the unused tail), then gates the processor with run / single-step / halt.
module prog_sequencer
  import proc_pkg::*;
#(
  parameter int PROG_DEPTH = PROG_DEPTH_DEF,
  parameter int WORD_W     = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              run_cmd,
  input  logic              halt_cmd,
  input  logic              step_cmd,
  output logic              pm_we,
  output logic [7:0]        pm_addr,
  output logic [WORD_W-1:0] pm_wdata,
  output logic              core_en,
  output logic              core_restart,
  output logic              load_done,
  output logic [8:0]        word_count,
  output logic [2:0]        state
);

  seq_state_t        r_state;
  logic              r_pm_we;
  logic [7:0]        r_pm_addr;
  logic [WORD_W-1:0] r_pm_wdata;
  logic              r_core_en;
  logic              r_core_restart;
  logic              r_load_done;
  logic              r_done_pend;    // last write issued; load_done next cycle
  logic              r_fresh;        // new program not yet started
  logic              r_restart_wait; // restart pulse issued, core_en follows
  logic [8:0]        r_word_count;

  logic       w_idle;
  logic       w_accept;
  logic       w_go_step;
  logic       w_go_run;
  logic       w_go_load;
  logic       w_ctr_inc;
  logic       w_ctr_tc;
  logic       w_fresh;
  logic [7:0] w_addr;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_accept  = load_valid && (r_state == ST_LOAD);
  assign w_go_step = w_idle && !halt_cmd && step_cmd;
  assign w_go_run  = w_idle && !halt_cmd && !step_cmd && run_cmd;
  assign w_go_load = w_idle && !halt_cmd && !step_cmd && !run_cmd && load_start;
  assign w_ctr_inc = w_accept || (r_state == ST_FILL);
  // The fresh flag is set together with load_done; a start command in that
  // same cycle must still see the program as fresh.
  assign w_fresh   = r_fresh || r_done_pend;

  prog_addr_ctr #(
    .DEPTH(PROG_DEPTH)
  ) u_addr_ctr (
    .clk    (clk),
    .reset_n(reset_n),
    .i_clr  (w_go_load),
    .i_inc  (w_ctr_inc),
    .o_count(w_addr),
    .o_tc   (w_ctr_tc)
  );

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_pm_we        <= 1'b0;
      r_pm_addr      <= '0;
      r_pm_wdata     <= '0;
      r_core_en      <= 1'b0;
      r_core_restart <= 1'b0;
      r_load_done    <= 1'b0;
      r_done_pend    <= 1'b0;
      r_fresh        <= 1'b0;
      r_restart_wait <= 1'b0;
      r_word_count   <= '0;
    end else begin
      r_pm_we        <= 1'b0;
      r_core_restart <= 1'b0;
      r_load_done    <= r_done_pend;
      r_done_pend    <= 1'b0;
      if (r_done_pend) begin
        r_fresh <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          r_core_en <= 1'b0;
          if (w_go_step || w_go_run) begin
            r_state <= w_go_step ? ST_STEP : ST_RUN;
            if (w_fresh) begin
              r_core_restart <= 1'b1;
              r_restart_wait <= 1'b1;
              r_fresh        <= 1'b0;
            end else begin
              r_core_en <= 1'b1;
            end
          end else if (w_go_load) begin
            r_state      <= ST_LOAD;
            r_word_count <= '0;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_pm_we      <= 1'b1;
            r_pm_addr    <= w_addr;
            r_pm_wdata   <= load_data;
            r_word_count <= r_word_count + 9'd1;
            // Final address wins over load_last: no fill is needed.
            if (w_ctr_tc) begin
              r_state     <= ST_IDLE;
              r_done_pend <= 1'b1;
            end else if (load_last) begin
              r_state <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          r_pm_we    <= 1'b1;
          r_pm_addr  <= w_addr;
          r_pm_wdata <= '0;
          if (w_ctr_tc) begin
            r_state     <= ST_IDLE;
            r_done_pend <= 1'b1;
          end
        end
        ST_RUN: begin
          r_restart_wait <= 1'b0;
          if (halt_cmd) begin
            r_state   <= ST_IDLE;
            r_core_en <= 1'b0;
          end else begin
            r_core_en <= 1'b1;
          end
        end
        ST_STEP: begin
          r_restart_wait <= 1'b0;
          if (r_restart_wait && !halt_cmd) begin
            r_core_en <= 1'b1;
          end else begin
            r_core_en <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_core_en <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready   = (r_state == ST_LOAD);
  assign pm_we        = r_pm_we;
  assign pm_addr      = r_pm_addr;
  assign pm_wdata     = r_pm_wdata;
  assign core_en      = r_core_en;
  assign core_restart = r_core_restart;
  assign load_done    = r_load_done;
  assign word_count   = r_word_count;
  assign state        = r_state;

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL have parameter PROG_DEPTH, default 256, number of program-memory words (power of two, 2..256).
REQ-002 SHALL have parameter WORD_W, default 10, program-word width.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 reset_n  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 load_start  in  1  pulse: begin program download (honoured in IDLE only).
REQ-006 load_valid  in  1  download word valid; load_data  in  WORD_W  word; load_last  in  1  marks final word.
REQ-007 load_ready  out  1  sequencer accepts a word this cycle.
REQ-008 run_cmd, halt_cmd, step_cmd  in  1 each  host execution commands, level-sampled.
REQ-009 pm_we  out  1; pm_addr  out  8; pm_wdata  out  WORD_W  program-memory write port, registered.
REQ-010 core_en  out  1  clock enable to the processor; core_restart  out  1  one-cycle pulse forcing the processor fetch pointer to its start value.
REQ-011 load_done  out  1  one-cycle pulse at end of download; word_count  out  9  number of words accepted in the last download.
REQ-012 state  out  3  current state encoding.

Function
REQ-013 States SHALL be IDLE, LOAD, FILL, RUN, STEP; reset state IDLE.
REQ-014 load_ready SHALL be 1 only in LOAD; a word is accepted when load_valid and load_ready are both 1.
REQ-015 Each accepted word SHALL produce pm_we=1, pm_addr=current address, pm_wdata=load_data in the next cycle; address starts at 0 and increments by 1 per accepted word.
REQ-016 IDLE to LOAD on load_start; the address counter and word_count SHALL clear on entry.
REQ-017 LOAD SHALL exit on the accepted word having load_last=1 or address PROG_DEPTH-1, whichever comes first; load_last on the final address SHALL behave identically to reaching the final address.
REQ-018 If exit occurs with fewer than PROG_DEPTH words, FILL SHALL write zero to every remaining address, one per cycle, with load_ready=0, then go to IDLE.
REQ-019 load_done SHALL pulse in the cycle after the last write (download or fill); a fresh flag SHALL be set at the same time.
REQ-020 In IDLE, priority SHALL be halt_cmd (stay IDLE) > step_cmd > run_cmd > load_start.
REQ-021 IDLE to RUN on run_cmd: core_en=1 from the next cycle and stays 1 until halt_cmd is seen; core_en=0 in the cycle after halt_cmd, and state returns to IDLE.
REQ-022 IDLE to STEP on step_cmd: core_en=1 for exactly one cycle, then IDLE; a held step_cmd SHALL give one step per IDLE/STEP pair (one step every 2 cycles).
REQ-023 On the first RUN or STEP entry with the fresh flag set, core_restart SHALL pulse one cycle before core_en rises; the fresh flag then clears.
REQ-024 run_cmd, step_cmd and load_start SHALL be ignored in LOAD, FILL, RUN, STEP; halt_cmd SHALL be ignored in LOAD and FILL.
REQ-025 core_en SHALL be 0 in IDLE, LOAD, FILL; pm_we SHALL never be 1 while core_en is 1.
REQ-026 word_count SHALL equal accepted words (1..PROG_DEPTH), excluding fill writes; it holds until the next load_start.

Reset
REQ-027 reset_n=0 SHALL force IDLE, all outputs 0, fresh flag 0, counters 0, on the next posedge, including mid-LOAD, mid-FILL and mid-RUN.
REQ-028 No partial write SHALL issue after reset: a word accepted in the reset cycle is discarded.

Structure
REQ-029 State encodings, PROG_DEPTH and WORD_W defaults SHALL live in shared package proc_pkg, together with the processor's opcode constants.
REQ-030 The address/fill counter SHALL be a sub-module prog_addr_ctr (clear, increment, terminal-count output); everything else stays flat.

Verification
REQ-031 Reset, load_start, 3 words 0x0AA, 0x155, 0x3FF (last on 3rd) -> writes addr 0..2 with those values, zeros at 3..255, load_done once, word_count=3.
REQ-032 Download of 256 words, no load_last -> no FILL cycles, load_done the cycle after addr 255 write, word_count=256.
REQ-033 After load, run_cmd -> core_restart pulse, then core_en=1; halt_cmd 10 cycles later -> core_en=0 next cycle; second run_cmd -> no core_restart.
REQ-034 step_cmd held 6 cycles from IDLE -> exactly 3 single-cycle core_en pulses; halt_cmd+step_cmd together -> none.
REQ-035 reset_n low at word 5 of a 20-word download with load_valid stuck high -> IDLE, pm_we=0, load_ready=0 next cycle, no write for word 5.
